// File: rtl/mult_bcd_seq.sv
// Sequential 3-digit BCD multiplier: converts both operands to binary over
// three cycles, then forms the 20-bit product with a 10-step shift-add.
module mult_bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] first_num,
    input  logic [11:0] second_num,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [19:0] product
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        MULT    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [11:0] a_reg, b_reg;
    logic [9:0]  a_bin, b_bin;
    logic [9:0]  a_next, b_next;
    logic [19:0] mcand;
    logic [9:0]  mplier;
    logic [19:0] p_acc;
    logic [19:0] addend;
    logic [3:0]  cnt;
    logic        bad_digit;

    function automatic logic [9:0] times10_add(input logic [9:0] acc, input logic [3:0] d);
        logic [13:0] t;
        t = 14'(acc) * 14'd10 + 14'(d);
        return t[9:0];
    endfunction

    function automatic logic has_bad_nibble(input logic [11:0] v);
        return (v[11:8] > 4'd9) || (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
    endfunction

    assign bad_digit = has_bad_nibble(first_num) || has_bad_nibble(second_num);
    assign a_next    = times10_add(a_bin, a_reg[11:8]);
    assign b_next    = times10_add(b_bin, b_reg[11:8]);
    assign addend    = mplier[0] ? mcand : 20'd0;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = bad_digit ? DONE : CONVERT;
            CONVERT: if (cnt == 4'd2) state_nxt = MULT;
            MULT:    if (cnt == 4'd9) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every datapath register is cleared by reset (no memories here),
    // so an aborted operation leaves no stale partial results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            a_bin   <= '0;
            b_bin   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            p_acc   <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            product <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= first_num;
                        b_reg   <= second_num;
                        a_bin   <= '0;
                        b_bin   <= '0;
                        p_acc   <= '0;
                        cnt     <= '0;
                        err     <= bad_digit;
                        product <= '0;
                    end
                end
                CONVERT: begin
                    // Hundreds digit is always at the top; shift the next one up.
                    a_bin <= a_next;
                    b_bin <= b_next;
                    a_reg <= {a_reg[7:0], 4'd0};
                    b_reg <= {b_reg[7:0], 4'd0};
                    if (cnt == 4'd2) begin
                        mcand  <= {10'd0, a_next};
                        mplier <= b_next;
                        p_acc  <= '0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                MULT: begin
                    p_acc  <= p_acc + addend;
                    mcand  <= {mcand[18:0], 1'b0};
                    mplier <= {1'b0, mplier[9:1]};
                    if (cnt == 4'd9) begin
                        product <= p_acc + addend;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule
